// File: rtl/mem_pkg.sv
// Shared types for the data memory port: access size encoding,
// the response bundle and the load-data extension helper.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef struct packed {
        logic        write;
        logic        err;
        logic [63:0] rdata;
    } mem_rsp_t;

    // Sign- or zero-extend the low (1<<size) bytes of data to 64 bits.
    function automatic logic [63:0] mem_extend(
        input logic [63:0] data,
        input mem_size_e   size,
        input logic        is_unsigned
    );
        logic [63:0] r;
        r = data;
        unique case (size)
            MEM_B: r = {{56{~is_unsigned & data[7]}},  data[7:0]};
            MEM_H: r = {{48{~is_unsigned & data[15]}}, data[15:0]};
            MEM_W: r = {{32{~is_unsigned & data[31]}}, data[31:0]};
            MEM_D: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency response pipe: valid-tagged shift register, async active-low clear.
// Ports: clk, rst_n, i_valid/i_data in, o_valid/o_data out after READ_LAT edges.
module mem_rsp_pipe
    import mem_pkg::*;
#(
    parameter int  READ_LAT = 1,
    parameter type T        = mem_rsp_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    input  T     i_data,
    output logic o_valid,
    output T     o_data
);

    logic r_vld [READ_LAT];
    T     r_dat [READ_LAT];

    // Bubbles carry zero data so the outputs idle at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_vld[i] <= 1'b0;
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            r_dat[0] <= i_valid ? i_data : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign o_valid = r_vld[READ_LAT-1];
    assign o_data  = r_dat[READ_LAT-1];

endmodule

// File: rtl/data_memory_port.sv
// Byte-addressable data memory behind a valid/ready request port with a
// fixed-latency, in-order response pipe and sub-word load/store support.
// Ports: clk, rst (active-low, async); req_* request in, req_ready_o;
//        rsp_valid_o pulse with rsp_write_o, rsp_err_o, rsp_rdata_o.
module data_memory_port
    import mem_pkg::*;
#(
    parameter int                AWIDTH      = 32,
    parameter int                DWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = 32'h01000000,
    parameter int                DEPTH_BYTES = 1 << 20,
    parameter int                READ_LAT    = 1,
    parameter string             INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_write_o,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int                NB      = DWIDTH / 8;
    localparam int                OW      = $clog2(DEPTH_BYTES);
    localparam logic [1:0]        MAX_SZ  = (DWIDTH == 64) ? 2'd3 : 2'd2;
    localparam logic [AWIDTH-1:0] DEPTH_A = AWIDTH'(DEPTH_BYTES);

    localparam logic [0:0] S_WARM = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    typedef struct packed {
        logic              write;
        logic              err;
        logic [DWIDTH-1:0] rdata;
    } rsp_t;

    logic [0:0]        r_state;
    logic [7:0]        r_mem [DEPTH_BYTES];

    logic              w_accept;
    logic              w_wr_en;
    logic [3:0]        w_nbytes;
    logic [2:0]        w_amask;
    logic [AWIDTH-1:0] w_off;
    logic [OW-1:0]     w_idx;
    logic              w_err_size;
    logic              w_err_align;
    logic              w_err_low;
    logic              w_err_high;
    logic              w_err;
    logic [DWIDTH-1:0] w_raw;
    rsp_t              w_pipe_in;
    rsp_t              w_pipe_out;
    logic              w_pipe_vld;

    // One warm-up cycle after reset release before accepting requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_WARM;
        end else begin
            case (r_state)
                S_WARM:  r_state <= S_RUN;
                S_RUN:   r_state <= S_RUN;
                default: r_state <= S_WARM;
            endcase
        end
    end

    assign req_ready_o = (r_state == S_RUN);
    assign w_accept    = req_valid_i & req_ready_o;

    assign w_nbytes = 4'd1 << req_size_i;
    assign w_amask  = 3'(w_nbytes - 4'd1);
    assign w_off    = req_addr_i - BASE_ADDR;
    assign w_idx    = w_off[OW-1:0];

    // Low addresses are caught by the compare; the subtract may wrap.
    assign w_err_size  = req_size_i > MAX_SZ;
    assign w_err_align = |(req_addr_i[2:0] & w_amask);
    assign w_err_low   = req_addr_i < BASE_ADDR;
    assign w_err_high  = w_off > (DEPTH_A - AWIDTH'(w_nbytes));
    assign w_err = w_err_size | w_err_align | w_err_low | w_err_high;

    assign w_wr_en = w_accept & req_write_i & ~w_err;

    // Storage is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (4'(i) < w_nbytes) begin
                    r_mem[w_idx + OW'(i)] <= req_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Bytes above the access size are discarded by the extension.
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < NB; i++) begin
            w_raw[8*i +: 8] = r_mem[w_idx + OW'(i)];
        end
    end

    always_comb begin
        w_pipe_in       = '0;
        w_pipe_in.write = req_write_i;
        w_pipe_in.err   = w_err;
        if (!req_write_i && !w_err) begin
            w_pipe_in.rdata = DWIDTH'(mem_extend(64'(w_raw),
                                                 mem_size_e'(req_size_i),
                                                 req_unsigned_i));
        end
    end

    mem_rsp_pipe #(
        .READ_LAT (READ_LAT),
        .T        (rsp_t)
    ) u_rsp_pipe (
        .clk     (clk),
        .rst_n   (rst),
        .i_valid (w_accept),
        .i_data  (w_pipe_in),
        .o_valid (w_pipe_vld),
        .o_data  (w_pipe_out)
    );

    assign rsp_valid_o = w_pipe_vld;
    assign rsp_write_o = w_pipe_out.write;
    assign rsp_err_o   = w_pipe_out.err;
    assign rsp_rdata_o = w_pipe_out.rdata;

endmodule
